// File: rtl/vm_barrido_sel_if.sv
// Bundle between the channel-scan sequencer and its surroundings:
// the scan request and configuration, the mux select/sample path, and the sweep results.
interface vm_barrido_sel_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               cont;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               sal;
  logic               sel0;
  logic               sel1;
  logic [3:0]         muestras;
  logic               valido;
  logic               ocupado;

  modport master (
    output start, cont, mask, dwell, sal,
    input  sel0, sel1, muestras, valido, ocupado
  );

  modport slave (
    input  start, cont, mask, dwell, sal,
    output sel0, sel1, muestras, valido, ocupado
  );
endinterface

// File: rtl/vm_barrido_sel.sv
// Channel-scan sequencer for a 4:1 mux: walks the enabled inputs in ascending order,
// holds each one for dwell+1 cycles, samples sal at the end of each hold and publishes a full sweep.
module vm_barrido_sel #(
  parameter int DWELL_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  vm_barrido_sel_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [1:0]         sel;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_l;
  logic [3:0]         mask_l;
  logic [3:0]         shadow;
  logic [3:0]         shadow_n;
  logic [3:0]         muestras;
  logic               valido;
  logic               ocupado;
  logic [3:0]         higher;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else if (m[2]) lowest = 2'd2;
    else           lowest = 2'd3;
  endfunction

  // Enabled channels strictly above cur: mask off bits 0..cur.
  function automatic logic [3:0] above(input logic [3:0] m, input logic [1:0] cur);
    logic [3:0] upto;
    upto  = (4'b0010 << cur) - 4'd1;
    above = m & ~upto;
  endfunction

  always_comb begin
    shadow_n      = shadow;
    shadow_n[sel] = bus.sal;
    higher        = above(mask_l, sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      cnt      <= '0;
      dwell_l  <= '0;
      mask_l   <= 4'd0;
      shadow   <= 4'd0;
      muestras <= 4'd0;
      valido   <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      valido <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.mask != 4'd0)) begin
            mask_l  <= bus.mask;
            dwell_l <= bus.dwell;
            shadow  <= 4'd0;
            cnt     <= '0;
            sel     <= lowest(bus.mask);
            ocupado <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != dwell_l) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (higher != 4'd0) begin
              shadow <= shadow_n;
              sel    <= lowest(higher);
            end else begin
              muestras <= shadow_n & mask_l;
              valido   <= 1'b1;
              if (bus.cont && (bus.mask != 4'd0)) begin
                // Back-to-back sweep: new configuration takes effect with no idle gap.
                mask_l  <= bus.mask;
                dwell_l <= bus.dwell;
                shadow  <= 4'd0;
                sel     <= lowest(bus.mask);
              end else begin
                shadow  <= 4'd0;
                sel     <= 2'd0;
                ocupado <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel0     = sel[0];
  assign bus.sel1     = sel[1];
  assign bus.muestras = muestras;
  assign bus.valido   = valido;
  assign bus.ocupado  = ocupado;

endmodule

// File: tb/tb_vm_barrido_sel.sv
// Directed bench for vm_barrido_sel: a behavioural 4:1 mux feeds sal from data word d,
// and each step checks select, sample and handshake outputs against hand-computed values.
module tb_vm_barrido_sel;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  int         nvec;
  int         nerr;

  vm_barrido_sel_if #(.DWELL_W(8)) bus ();

  vm_barrido_sel #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.sal = d[{bus.sel1, bus.sel0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] selv();
    return {6'd0, bus.sel1, bus.sel0};
  endfunction

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    d         = 4'b1010;
    bus.start = 1'b0;
    bus.cont  = 1'b0;
    bus.mask  = 4'b1111;
    bus.dwell = 8'd0;
    tick();
    tick();
    chk("rst_sel", selv(), 8'd0);
    chk("rst_muestras", {4'd0, bus.muestras}, 8'd0);
    chk("rst_valido", {7'd0, bus.valido}, 8'd0);
    chk("rst_ocupado", {7'd0, bus.ocupado}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Full sweep, D=1010, mask=1111, dwell=0, single mode
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("full_sel0", selv(), 8'd0);
    chk("full_ocup", {7'd0, bus.ocupado}, 8'd1);
    tick();
    chk("full_sel1", selv(), 8'd1);
    tick();
    chk("full_sel2", selv(), 8'd2);
    tick();
    chk("full_sel3", selv(), 8'd3);
    chk("full_novld", {7'd0, bus.valido}, 8'd0);
    tick();
    chk("full_vld", {7'd0, bus.valido}, 8'd1);
    chk("full_muestras", {4'd0, bus.muestras}, 8'b1010);
    chk("full_ocup_end", {7'd0, bus.ocupado}, 8'd0);
    chk("full_sel_idle", selv(), 8'd0);
    tick();
    chk("full_vld_pulse", {7'd0, bus.valido}, 8'd0);

    // Sparse mask 0101, dwell=2, D=1111
    d         = 4'b1111;
    bus.mask  = 4'b0101;
    bus.dwell = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sparse_sel_ch0", selv(), 8'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("sparse_sel_ch2", selv(), 8'd2);
      chk("sparse_novld", {7'd0, bus.valido}, 8'd0);
      tick();
    end
    chk("sparse_vld", {7'd0, bus.valido}, 8'd1);
    chk("sparse_muestras", {4'd0, bus.muestras}, 8'b0101);
    chk("sparse_ocup_end", {7'd0, bus.ocupado}, 8'd0);
    tick();

    // Continuous mode, mask 0011 then 1000 mid-sweep, dwell=1, D=1010
    d         = 4'b1010;
    bus.cont  = 1'b1;
    bus.mask  = 4'b0011;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mask  = 4'b1000;
    chk("cont_sel0", selv(), 8'd0);
    tick();
    chk("cont_sel0b", selv(), 8'd0);
    tick();
    chk("cont_sel1", selv(), 8'd1);
    tick();
    chk("cont_novld", {7'd0, bus.valido}, 8'd0);
    tick();
    chk("cont_vld1", {7'd0, bus.valido}, 8'd1);
    chk("cont_muestras1", {4'd0, bus.muestras}, 8'b0010);
    chk("cont_sel3", selv(), 8'd3);
    chk("cont_ocup1", {7'd0, bus.ocupado}, 8'd1);
    tick();
    chk("cont_vld_gap", {7'd0, bus.valido}, 8'd0);
    chk("cont_sel3b", selv(), 8'd3);
    chk("cont_ocup2", {7'd0, bus.ocupado}, 8'd1);
    tick();
    chk("cont_vld2", {7'd0, bus.valido}, 8'd1);
    chk("cont_muestras2", {4'd0, bus.muestras}, 8'b1000);
    chk("cont_ocup3", {7'd0, bus.ocupado}, 8'd1);
    bus.cont = 1'b0;
    tick();
    chk("cont_vld_gap2", {7'd0, bus.valido}, 8'd0);
    tick();
    chk("cont_vld3", {7'd0, bus.valido}, 8'd1);
    chk("cont_ocup_end", {7'd0, bus.ocupado}, 8'd0);
    chk("cont_sel_idle", selv(), 8'd0);

    // start with empty mask is ignored
    bus.mask  = 4'b0000;
    bus.start = 1'b1;
    tick();
    tick();
    chk("nomask_ocup", {7'd0, bus.ocupado}, 8'd0);
    chk("nomask_sel", selv(), 8'd0);
    bus.start = 1'b0;

    // start re-asserted mid-sweep is neither queued nor restarts the sweep
    bus.mask  = 4'b0001;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_ocup", {7'd0, bus.ocupado}, 8'd1);
    tick();
    bus.start = 1'b1;
    chk("restart_novld", {7'd0, bus.valido}, 8'd0);
    tick();
    bus.start = 1'b0;
    chk("restart_vld", {7'd0, bus.valido}, 8'd1);
    chk("restart_muestras", {4'd0, bus.muestras}, 8'b0000);
    chk("restart_ocup_end", {7'd0, bus.ocupado}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("restart_idle_ocup", {7'd0, bus.ocupado}, 8'd0);
      chk("restart_idle_vld", {7'd0, bus.valido}, 8'd0);
    end

    // Maximum dwell: 256-cycle hold on channel 0
    d         = 4'b1111;
    bus.mask  = 4'b0001;
    bus.dwell = 8'd255;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("maxdw_hold", {5'd0, bus.valido, bus.sel1, bus.sel0}, 8'd0);
      tick();
    end
    chk("maxdw_vld", {7'd0, bus.valido}, 8'd1);
    chk("maxdw_muestras", {4'd0, bus.muestras}, 8'b0001);
    tick();
    chk("maxdw_vld_pulse", {7'd0, bus.valido}, 8'd0);

    // Asynchronous reset in the middle of a sweep
    bus.mask  = 4'b1111;
    bus.dwell = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("arst_pre_sel", selv(), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", selv(), 8'd0);
    chk("arst_ocup", {7'd0, bus.ocupado}, 8'd0);
    chk("arst_muestras", {4'd0, bus.muestras}, 8'd0);
    chk("arst_vld", {7'd0, bus.valido}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_hold_vld", {7'd0, bus.valido}, 8'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("arst_after_vld", {6'd0, bus.valido, bus.ocupado}, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vm_barrido_sel.md
# vm_barrido_sel

Channel-scan sequencer that sits directly upstream of the 4:1 multiplexer and drives its `sel0`/`sel1` select lines. It walks through the enabled inputs in ascending order, holds each selection for a programmable dwell time and samples the multiplexer output `sal` at the end of each hold. After a complete sweep it publishes all four sampled bits at once. It supports single-shot and continuous scanning.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell-count input.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `start`  input  1  level-sampled request to begin a sweep; honoured only in IDLE.
- `cont`  input  1  1 = continuous sweeps, 0 = single sweep. Sampled at each sweep end.
- `mask`  input  4  channel enable, bit i = input Di. Latched at sweep start.
- `dwell`  input  DWELL_W  hold length minus one. Latched at sweep start.
- `sal`  input  1  multiplexer output being sampled.
- `sel0`  output  1  select LSB to the multiplexer; registered.
- `sel1`  output  1  select MSB to the multiplexer; registered.
- `muestras`  output  4  last completed sweep; bit i = sampled value of Di, 0 if disabled.
- `valido`  output  1  one-cycle pulse when `muestras` updates.
- `ocupado`  output  1  high while a sweep is in progress.

## Operation
- States:
  - IDLE: `sel` = 00, `ocupado` = 0.
  - HOLD: a channel is selected and the dwell counter is running.
- IDLE → HOLD: on an edge with `start` = 1 and `mask` ≠ 0.
  - Latch `mask` and `dwell`.
  - Clear the shadow sample register and the dwell counter.
  - Set `sel` to the lowest enabled channel and `ocupado` to 1.
- `start` is ignored when `mask` = 0 and while HOLD is active; it is not queued.
- HOLD, counter < latched dwell: increment the counter.
- HOLD, counter = latched dwell (end-of-hold edge):
  - Write `sal` into shadow bit `{sel1,sel0}` and clear the counter.
  - If a higher enabled channel exists, move `sel` to the next higher enabled channel.
  - Otherwise (sweep end):
    - Copy shadow to `muestras` (disabled bits 0) and pulse `valido`.
    - If `cont` = 1: re-latch `mask`/`dwell` and select the lowest enabled channel of the new mask, staying in HOLD.
    - If `cont` = 1 and the new mask is 0: go to IDLE.
    - If `cont` = 0: go to IDLE.
- Disabled channels are never selected; no cycles are spent on them.
- `mask`/`dwell` changes during a sweep have no effect until the next sweep.
- Dwell counter width is DWELL_W; maximum hold is 2^DWELL_W cycles, with no overflow.

## Timing
- Reset values:
  - `sel0` = `sel1` = 0, `muestras` = 0000, `valido` = 0, `ocupado` = 0.
  - State IDLE; counter and shadow cleared.
- Reset mid-sweep: all outputs go to their reset values immediately, without waiting for a clock edge. The partial sweep is discarded.
- Each enabled channel is held for exactly `dwell`+1 cycles. `sal` is sampled on the edge that ends the hold, and `sel` changes on that same edge.
- Sweep length = N·(`dwell`+1) cycles, where N = popcount(latched mask).
- From the `start` edge (edge 0), `valido` is visible high in the cycle after edge N·(`dwell`+1).
- Continuous mode: no gap between sweeps. `valido` repeats every N·(`dwell`+1) cycles, and `ocupado` stays high throughout.
- Single mode: `ocupado` falls on the same edge that raises `valido`. A new `start` is accepted from the next edge.
- The multiplexer path from `sel` to `sal` is combinational and must settle within one cycle. `dwell` = 0 is legal.

## Test plan
- Reset: assert `rst_n` = 0 mid-sweep with `mask` = 1111, `dwell` = 5 → within the same cycle `sel` = 00, `ocupado` = 0, `muestras` = 0000, and no `valido` pulse follows.
- Full sweep: multiplexer model with D3..D0 = 1010, `mask` = 1111, `dwell` = 0, `cont` = 0, `start` pulsed → `sel` = 0,1,2,3 for one cycle each; `muestras` = 1010 and `valido` = 1 for one cycle 4 cycles after start; `ocupado` = 0 afterward.
- Sparse mask: D = 1111, `mask` = 0101, `dwell` = 2 → `sel` = 0 for 3 cycles, then 2 for 3 cycles; `muestras` = 0101; `valido` 6 cycles after start.
- Continuous mode: `cont` = 1, `mask` = 0011, `dwell` = 1; change `mask` to 1000 mid-sweep → first sweep still covers channels 0 and 1 with `valido` at 4 cycles; the next sweep holds channel 3 only, with `valido` at 2-cycle spacing; `ocupado` stays 1.
- Ignored requests: `start` with `mask` = 0000 → stays IDLE, `ocupado` = 0. `start` re-asserted during a sweep → sweep timing unchanged and no extra sweep follows.
- Max dwell: `DWELL_W` = 8, `dwell` = 255, `mask` = 0001 → `sel` held at 00 for 256 cycles, then a single `valido` pulse.
